// File: rtl/uart_packet_deframer_pkg.sv
// Shared types and constants for the UART packet deframer: opcodes, FSM state
// encodings and header geometry.
package uart_packet_deframer_pkg;

    localparam int HEADER_BYTES = 4;

    typedef enum logic [7:0] {
        OP_ECHO = 8'hEC,
        OP_ADD  = 8'hAD,
        OP_MUL  = 8'h88,
        OP_DIV  = 8'hD1
    } opcode_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_OPCODE  = 3'd0;
    localparam state_t ST_RSVD    = 3'd1;
    localparam state_t ST_LEN_LO  = 3'd2;
    localparam state_t ST_LEN_HI  = 3'd3;
    localparam state_t ST_PAYLOAD = 3'd4;
    localparam state_t ST_HOLD    = 3'd5;
    localparam state_t ST_DRAIN   = 3'd6;

    function automatic logic is_alu_op(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/uart_packet_deframer.sv
// Byte-stream to packet deframer: parses a 4-byte header, then emits echo bytes
// or little-endian 32-bit operand words; malformed packets are drained.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   OPCODE  | waiting for first header byte, latches opcode
//   RSVD    | reserved header byte, ignored
//   LEN_LO  | latches low byte of total packet length
//   LEN_HI  | latches high byte, validates header, picks next state
//   PAYLOAD | accepting payload bytes into echo register or word shifter
//   HOLD    | output valid, waiting for downstream handshake
//   DRAIN   | discarding payload of a rejected packet
module uart_packet_deframer
    import uart_packet_deframer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  echo_data_o,
    output logic        echo_valid_o,
    input  logic        echo_ready_i,
    output logic [31:0] word_data_o,
    output logic [7:0]  word_op_o,
    output logic        word_last_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        err_o
);

    state_t      state;
    logic [7:0]  opcode_q;
    logic [7:0]  len_lo_q;
    logic [15:0] remaining;
    logic [1:0]  byte_idx;

    logic        rx_fire;
    logic        out_fire;
    logic [15:0] len_full;
    logic [15:0] len_payload;
    logic        len_short;
    logic [15:0] rem_dec;
    logic        op_is_echo;
    logic        op_is_alu;

    assign rx_ready_o  = (state != ST_HOLD);
    assign rx_fire     = rx_valid_i && rx_ready_o;
    assign out_fire    = (echo_valid_o && echo_ready_i) || (word_valid_o && word_ready_i);
    assign word_op_o   = opcode_q;

    assign len_full    = {rx_data_i, len_lo_q};
    assign len_payload = len_full - 16'(HEADER_BYTES);
    assign len_short   = len_full < 16'(HEADER_BYTES);
    assign rem_dec     = remaining - 16'd1;
    assign op_is_echo  = (opcode_q == OP_ECHO);
    assign op_is_alu   = is_alu_op(opcode_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_OPCODE;
            opcode_q     <= 8'h00;
            len_lo_q     <= 8'h00;
            remaining    <= 16'h0000;
            byte_idx     <= 2'd0;
            echo_data_o  <= 8'h00;
            echo_valid_o <= 1'b0;
            word_data_o  <= 32'h0000_0000;
            word_last_o  <= 1'b0;
            word_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_OPCODE: begin
                    if (rx_fire) begin
                        opcode_q <= rx_data_i;
                        state    <= ST_RSVD;
                    end
                end

                ST_RSVD: begin
                    if (rx_fire) begin
                        state <= ST_LEN_LO;
                    end
                end

                ST_LEN_LO: begin
                    if (rx_fire) begin
                        len_lo_q <= rx_data_i;
                        state    <= ST_LEN_HI;
                    end
                end

                ST_LEN_HI: begin
                    if (rx_fire) begin
                        remaining <= len_payload;
                        byte_idx  <= 2'd0;
                        if (len_short) begin
                            remaining <= 16'h0000;
                            err_o     <= 1'b1;
                            state     <= ST_OPCODE;
                        end else if (op_is_echo) begin
                            state <= (len_payload == 16'h0000) ? ST_OPCODE : ST_PAYLOAD;
                        end else if (op_is_alu) begin
                            // ALU payload must be a non-empty whole number of words
                            if (len_payload == 16'h0000) begin
                                err_o <= 1'b1;
                                state <= ST_OPCODE;
                            end else if (len_payload[1:0] != 2'b00) begin
                                err_o <= 1'b1;
                                state <= ST_DRAIN;
                            end else begin
                                state <= ST_PAYLOAD;
                            end
                        end else begin
                            err_o <= 1'b1;
                            state <= (len_payload == 16'h0000) ? ST_OPCODE : ST_DRAIN;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (rx_fire) begin
                        remaining <= rem_dec;
                        if (op_is_echo) begin
                            echo_data_o  <= rx_data_i;
                            echo_valid_o <= 1'b1;
                            state        <= ST_HOLD;
                        end else begin
                            word_data_o[8*byte_idx +: 8] <= rx_data_i;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                word_valid_o <= 1'b1;
                                word_last_o  <= (rem_dec == 16'h0000);
                                state        <= ST_HOLD;
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    if (out_fire) begin
                        echo_valid_o <= 1'b0;
                        word_valid_o <= 1'b0;
                        word_last_o  <= 1'b0;
                        state        <= (remaining == 16'h0000) ? ST_OPCODE : ST_PAYLOAD;
                    end
                end

                ST_DRAIN: begin
                    if (rx_fire) begin
                        remaining <= rem_dec;
                        if (remaining == 16'd1) begin
                            state <= ST_OPCODE;
                        end
                    end
                end

                default: begin
                    state <= ST_OPCODE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_packet_deframer.sv
// Scoreboard bench for uart_packet_deframer: stimulus pushes expected outputs,
// a negedge monitor pops and compares on every output handshake.
module tb_uart_packet_deframer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  echo_data_o;
    logic        echo_valid_o;
    logic        echo_ready_i = 1'b1;
    logic [31:0] word_data_o;
    logic [7:0]  word_op_o;
    logic        word_last_o;
    logic        word_valid_o;
    logic        word_ready_i = 1'b1;
    logic        err_o;

    uart_packet_deframer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .echo_data_o  (echo_data_o),
        .echo_valid_o (echo_valid_o),
        .echo_ready_i (echo_ready_i),
        .word_data_o  (word_data_o),
        .word_op_o    (word_op_o),
        .word_last_o  (word_last_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails  = 0;
    int err_seen = 0;
    int err_exp  = 0;

    logic [7:0]  echo_q[$];
    logic [31:0] wdata_q[$];
    logic        wlast_q[$];
    logic [7:0]  wop_q[$];
    logic [7:0]  pkt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: handshakes, hold stability, rx backpressure, err pulses
    logic        prev_w_stall = 1'b0;
    logic [31:0] prev_wd = '0;
    logic        prev_wl = 1'b0;
    logic        prev_e_stall = 1'b0;
    logic [7:0]  prev_ed = '0;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (err_o) err_seen++;
            if (prev_w_stall) begin
                chk("word_valid_held", {31'd0, word_valid_o}, 32'd1);
                chk("word_data_stable", word_data_o, prev_wd);
                chk("word_last_stable", {31'd0, word_last_o}, {31'd0, prev_wl});
            end
            if (prev_e_stall) begin
                chk("echo_valid_held", {31'd0, echo_valid_o}, 32'd1);
                chk("echo_data_stable", {24'd0, echo_data_o}, {24'd0, prev_ed});
            end
            if (word_valid_o || echo_valid_o)
                chk("rx_ready_low_in_hold", {31'd0, rx_ready_o}, 32'd0);
            if (echo_valid_o && echo_ready_i) begin
                if (echo_q.size() == 0) begin
                    chk("unexpected_echo", {24'd0, echo_data_o}, 32'hxxxx_xxxx);
                end else begin
                    chk("echo_data", {24'd0, echo_data_o}, {24'd0, echo_q.pop_front()});
                end
            end
            if (word_valid_o && word_ready_i) begin
                if (wdata_q.size() == 0) begin
                    chk("unexpected_word", word_data_o, 32'hxxxx_xxxx);
                end else begin
                    chk("word_data", word_data_o, wdata_q.pop_front());
                    chk("word_last", {31'd0, word_last_o}, {31'd0, wlast_q.pop_front()});
                    chk("word_op", {24'd0, word_op_o}, {24'd0, wop_q.pop_front()});
                end
            end
        end
        prev_w_stall = !rst_i && word_valid_o && !word_ready_i;
        prev_wd      = word_data_o;
        prev_wl      = word_last_o;
        prev_e_stall = !rst_i && echo_valid_o && !echo_ready_i;
        prev_ed      = echo_data_o;
    end

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        int   n;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk_i);
            ok = rx_ready_o;
            @(posedge clk_i);
            n++;
        end
        #1 rx_valid_i = 1'b0;
        if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic exp_word(input logic [31:0] d, input logic l, input logic [7:0] op);
        wdata_q.push_back(d);
        wlast_q.push_back(l);
        wop_q.push_back(op);
    endtask

    task automatic settle_and_check(input string name);
        int n = 0;
        while ((echo_q.size() != 0 || wdata_q.size() != 0) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        chk({name, "_echo_q_empty"}, echo_q.size(), 32'd0);
        chk({name, "_word_q_empty"}, wdata_q.size(), 32'd0);
        chk({name, "_err_count"}, err_seen, err_exp);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        chk("rst_echo_valid", {31'd0, echo_valid_o}, 32'd0);
        chk("rst_word_valid", {31'd0, word_valid_o}, 32'd0);
        chk("rst_word_last", {31'd0, word_last_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_echo_data", {24'd0, echo_data_o}, 32'd0);
        chk("rst_word_data", word_data_o, 32'd0);
        chk("rst_word_op", {24'd0, word_op_o}, 32'd0);
        @(posedge clk_i); #1;

        // Echo, two payload bytes
        echo_q.push_back(8'h41); echo_q.push_back(8'h42);
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        send_pkt();
        settle_and_check("echo");

        // ADD, two words
        exp_word(32'h0000_0001, 1'b0, 8'hAD);
        exp_word(32'hFFFF_FFFF, 1'b1, 8'hAD);
        pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_pkt();
        settle_and_check("add");

        // Backpressure on first word of a MUL packet
        exp_word(32'h1234_5678, 1'b0, 8'h88);
        exp_word(32'hCAFE_BABE, 1'b1, 8'h88);
        pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hBE, 8'hBA, 8'hFE, 8'hCA};
        word_ready_i = 1'b0;
        fork
            send_pkt();
            begin
                int n = 0;
                while (!word_valid_o && n < 200) begin
                    @(negedge clk_i);
                    n++;
                end
                chk("bp_word_valid_seen", {31'd0, word_valid_o}, 32'd1);
                repeat (10) @(negedge clk_i);
                @(posedge clk_i);
                #1 word_ready_i = 1'b1;
            end
        join
        settle_and_check("backpressure");

        // Bad length: 3-byte ALU payload drained, then an echo
        err_exp++;
        echo_q.push_back(8'h5A);
        pkt = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC,
                8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_pkt();
        settle_and_check("bad_len");

        // Unknown opcode with empty payload, then header shorter than 4
        err_exp += 2;
        pkt = '{8'h33, 8'h00, 8'h04, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00};
        send_pkt();
        settle_and_check("unknown_short");

        // Unknown opcode with payload drained, empty DIV (error), empty echo (ok)
        err_exp += 2;
        exp_word(32'hA1B2_C3D4, 1'b1, 8'hD1);
        pkt = '{8'h33, 8'h00, 8'h06, 8'h00, 8'h01, 8'h02,
                8'hD1, 8'h00, 8'h04, 8'h00,
                8'hEC, 8'h00, 8'h04, 8'h00,
                8'hD1, 8'h00, 8'h08, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        send_pkt();
        settle_and_check("drain_empty");

        // Reset after two payload bytes of a word
        pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22};
        send_pkt();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_word_valid", {31'd0, word_valid_o}, 32'd0);
        chk("midrst_word_data", word_data_o, 32'd0);
        chk("midrst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        exp_word(32'h0102_0304, 1'b1, 8'hAD);
        pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
        send_pkt();
        settle_and_check("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_packet_deframer.md
# uart_packet_deframer

Byte-to-packet deframer between the UART receiver and the ALU. Consumes the receiver's 8-bit valid/ready byte stream, parses the 4-byte header (opcode, reserved, 16-bit little-endian length), then emits echo bytes or little-endian 32-bit operand words tagged with opcode and a last flag. Malformed packets are discarded byte-for-byte so framing stays aligned with the host.

## Interface
- No parameters. Word width is fixed at 32; header size is fixed at 4 bytes.
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- rx_data_i  in  8  byte from UART receiver
- rx_valid_i  in  1  byte valid
- rx_ready_o  out  1  deframer accepts byte this cycle
- echo_data_o  out  8  echo payload byte
- echo_valid_o  out  1  echo byte valid
- echo_ready_i  in  1  downstream (UART TX) accepts echo byte
- word_data_o  out  32  operand, little-endian assembled
- word_op_o  out  8  opcode of current packet
- word_last_o  out  1  final operand of packet
- word_valid_o  out  1  operand valid
- word_ready_i  in  1  ALU accepts operand
- err_o  out  1  one-cycle pulse on malformed header

## Operation
- Byte transfer: rx_valid_i && rx_ready_o. Output transfers: valid && ready.
- States: OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, HOLD, DRAIN.
- OPCODE: latch opcode -> RSVD. RSVD: byte ignored -> LEN_LO. LEN_LO: latch low byte -> LEN_HI.
- LEN_HI: latch high byte; remaining = len - 4. Decision on accepting this byte:
  - len < 4: err_o pulse, -> OPCODE.
  - Opcode ECHO (0xEC): remaining == 0 -> OPCODE, else -> PAYLOAD.
  - Opcode ADD (0xAD), MUL (0x88), DIV (0xD1): remaining == 0 or remaining[1:0] != 0 -> err_o pulse; remaining == 0 -> OPCODE, else -> DRAIN. Otherwise -> PAYLOAD.
  - Any other opcode: err_o pulse; -> DRAIN if remaining != 0, else OPCODE.
- PAYLOAD, echo: each accepted byte is registered to echo_data_o, echo_valid_o set, remaining decremented; -> HOLD.
- PAYLOAD, ALU: bytes shift into word[8*k +: 8], k = 0..3. On the 4th byte, word_valid_o set, word_last_o = (remaining after decrement == 0); -> HOLD.
- HOLD: rx_ready_o low. On output handshake, clear valid; remaining == 0 -> OPCODE, else -> PAYLOAD.
- DRAIN: accepts and discards bytes; on the byte making remaining 0 -> OPCODE.
- word_op_o holds the latched opcode and is stable while word_valid_o is high.

## Timing
- Reset values: rx_ready_o 1 (state OPCODE), echo_valid_o 0, word_valid_o 0, word_last_o 0, err_o 0, echo_data_o/word_data_o/word_op_o 0.
- rx_ready_o is 1 in OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, and DRAIN; it is 0 in HOLD.
- Latency: a byte accepted at edge N drives echo_valid_o, or word_valid_o for the 4th byte, high after edge N. The first opportunity to accept the next byte is the cycle after the output handshake.
- Output valid held with stable data until ready; never withdrawn.
- err_o is high exactly one cycle, the cycle after the LEN_HI byte is accepted.
- Length 0xFFFF is legal; remaining is 16-bit with no wrap. Decrement only on accepted bytes.
- rst_i mid-packet: immediate return to OPCODE; partial word and pending outputs discarded.

## Structure
- config_pkg gets an opcode enum (OP_ECHO=0xEC, OP_ADD=0xAD, OP_MUL=0x88, OP_DIV=0xD1), the state enum type, and HEADER_BYTES=4.
- Single module; no sub-module. The FSM, the 16-bit remaining counter, and the 2-bit byte index are inline.

## Test plan
- Echo: EC 00 06 00 41 42 with echo_ready_i=1 -> echo bytes 0x41, 0x42 in order; err_o never set; state back to OPCODE.
- ADD: AD 00 0C 00 01 00 00 00 FF FF FF FF -> words 0x00000001 (last=0), 0xFFFFFFFF (last=1); word_op_o=0xAD.
- Backpressure: word_ready_i low 10 cycles on the first word -> word_valid_o and data stable; rx_ready_o low throughout; no byte lost.
- Bad length: AD 00 07 00 AA BB CC -> err_o pulse; three bytes drained; following EC 00 05 00 5A echoes 0x5A.
- Unknown opcode plus short length: 33 00 04 00 -> err_o pulse, no outputs. 10 00 02 00 -> err_o pulse, back to OPCODE.
- Reset mid-word: assert rst_i after 2 payload bytes -> outputs cleared; next packet parses correctly.
